// File: rtl/spi_slave_if_if.sv
// Bus bundle for the SPI mode-0 responder: pad-side SPI pins plus the
// parallel reply/receive side toward the display/readback logic.
interface spi_slave_if_if #(
    parameter int unsigned FRAME_BITS = 16,
    parameter int unsigned DATA_BITS  = 14
);
    logic                  sclk;
    logic                  mosi;
    logic                  ss;
    logic                  miso;
    logic [FRAME_BITS-1:0] i_tx_data;
    logic [DATA_BITS-1:0]  o_rx_data;
    logic                  o_data_valid;
    logic                  o_frame_err;
    logic                  o_busy;

    modport master (
        output sclk, mosi, ss, i_tx_data,
        input  miso, o_rx_data, o_data_valid, o_frame_err, o_busy
    );

    modport slave (
        input  sclk, mosi, ss, i_tx_data,
        output miso, o_rx_data, o_data_valid, o_frame_err, o_busy
    );
endinterface

// File: rtl/spi_slave_if.sv
// SPI mode-0 responder: oversamples sclk/mosi/ss in the clk domain, receives
// a FRAME_BITS word MSB first and shifts a reply word out on miso.
module spi_slave_if #(
    parameter int unsigned FRAME_BITS  = 16,
    parameter int unsigned DATA_BITS   = 14,
    parameter int unsigned SYNC_STAGES = 2
) (
    input logic           clk,
    input logic           reset,
    spi_slave_if_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(FRAME_BITS + 1);
    localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0] ONE_CNT   = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        DONE
    } state_t;

    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic [SYNC_STAGES-1:0] ss_sync_q, ss_sync_d;
    logic                   sclk_dly_q, sclk_dly_d;
    logic                   ss_dly_q, ss_dly_d;
    logic [SYNC_STAGES:0]   fill_q, fill_d;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-2:0]   rx_shift_q, rx_shift_d;
    logic [FRAME_BITS-1:0]  tx_shift_q, tx_shift_d;
    logic [DATA_BITS-1:0]   rx_data_q, rx_data_d;
    logic                   valid_q, valid_d;
    logic                   err_q, err_d;

    logic sclk_s, mosi_s, ss_s;
    logic sclk_rise, sclk_fall, ss_fall, ss_rise;

    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], bus.sclk};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], bus.mosi};
        ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0], bus.ss};
        sclk_dly_d  = sclk_sync_q[SYNC_STAGES-1];
        ss_dly_d    = ss_sync_q[SYNC_STAGES-1];
        fill_d      = {fill_q[SYNC_STAGES-1:0], 1'b1};
    end

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign ss_s      = ss_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_dly_q;
    assign sclk_fall = ~sclk_s & sclk_dly_q;
    assign ss_rise   = ss_s & ~ss_dly_q;
    // The ss preset would fake a fall if the pad is already low at reset
    // release; only trust ss once real samples fill the whole pipeline.
    assign ss_fall   = fill_q[SYNC_STAGES] & ~ss_s & ss_dly_q;

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        rx_shift_d = rx_shift_q;
        tx_shift_d = tx_shift_q;
        rx_data_d  = rx_data_q;
        valid_d    = 1'b0;
        err_d      = 1'b0;

        unique case (state_q)
            IDLE: begin
                tx_shift_d = '0;
                if (ss_fall) begin
                    tx_shift_d = bus.i_tx_data;
                    bit_cnt_d  = '0;
                    rx_shift_d = '0;
                    state_d    = ACTIVE;
                end
            end
            ACTIVE: begin
                // Only the low DATA_BITS survive, so the shifter keeps just
                // DATA_BITS-1 history bits and older bits fall off the top.
                if (sclk_rise) begin
                    rx_shift_d = {rx_shift_q[DATA_BITS-3:0], mosi_s};
                    bit_cnt_d  = bit_cnt_q + ONE_CNT;
                    if (bit_cnt_d == FRAME_CNT) begin
                        rx_data_d = {rx_shift_q, mosi_s};
                        valid_d   = 1'b1;
                        state_d   = DONE;
                    end
                end
                if (sclk_fall && bit_cnt_q >= ONE_CNT && bit_cnt_q < FRAME_CNT) begin
                    tx_shift_d = {tx_shift_q[FRAME_BITS-2:0], 1'b0};
                end
                if (ss_rise) begin
                    state_d    = IDLE;
                    tx_shift_d = '0;
                    err_d      = (bit_cnt_d != '0) && (bit_cnt_d != FRAME_CNT);
                end
            end
            DONE: begin
                if (ss_rise) begin
                    state_d    = IDLE;
                    tx_shift_d = '0;
                end
            end
            default: begin
                state_d    = IDLE;
                tx_shift_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            ss_sync_q   <= '1;
            sclk_dly_q  <= 1'b0;
            ss_dly_q    <= 1'b1;
            fill_q      <= '0;
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            rx_shift_q  <= '0;
            tx_shift_q  <= '0;
            rx_data_q   <= '0;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            sclk_sync_q <= sclk_sync_d;
            mosi_sync_q <= mosi_sync_d;
            ss_sync_q   <= ss_sync_d;
            sclk_dly_q  <= sclk_dly_d;
            ss_dly_q    <= ss_dly_d;
            fill_q      <= fill_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_shift_q  <= rx_shift_d;
            tx_shift_q  <= tx_shift_d;
            rx_data_q   <= rx_data_d;
            valid_q     <= valid_d;
            err_q       <= err_d;
        end
    end

    assign bus.miso         = tx_shift_q[FRAME_BITS-1];
    assign bus.o_rx_data    = rx_data_q;
    assign bus.o_data_valid = valid_q;
    assign bus.o_frame_err  = err_q;
    assign bus.o_busy       = (state_q == ACTIVE) || (state_q == DONE);
endmodule

// File: tb/tb_spi_slave_if.sv
// Directed bench for spi_slave_if: full, aborted, overrun, reset-interrupted
// and back-to-back frames at a 1 MHz sclk against a 100 MHz clk.
module tb_spi_slave_if;
    localparam int HALF = 50;

    logic clk;
    logic reset;
    int   checks;
    int   failures;
    int   valid_cnt;
    int   err_cnt;
    int   v0;
    int   e0;
    logic [15:0] mw;
    logic        mb;

    spi_slave_if_if #(.FRAME_BITS(16), .DATA_BITS(14)) bus ();

    spi_slave_if #(.FRAME_BITS(16), .DATA_BITS(14), .SYNC_STAGES(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.o_data_valid === 1'b1) valid_cnt++;
        if (bus.o_frame_err === 1'b1) err_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic sclk_bit(input logic b, output logic m);
        bus.mosi = b;
        wait_clk(HALF);
        m = bus.miso;
        bus.sclk = 1'b1;
        wait_clk(HALF);
        bus.sclk = 1'b0;
    endtask

    task automatic spi_xfer(input logic [15:0] word, input logic [15:0] tx,
                            input int nbits, input int gap, output logic [15:0] mo);
        logic m;
        mo = '0;
        bus.i_tx_data = tx;
        bus.ss = 1'b0;
        wait_clk(HALF);
        for (int i = 0; i < nbits; i++) begin
            sclk_bit((i < 16) ? word[15-i] : 1'b1, m);
            if (i < 16) mo[15-i] = m;
        end
        wait_clk(HALF);
        bus.ss = 1'b1;
        wait_clk(gap);
    endtask

    initial begin
        checks = 0; failures = 0; valid_cnt = 0; err_cnt = 0;
        reset = 1'b0;
        bus.sclk = 1'b0; bus.mosi = 1'b0; bus.ss = 1'b1; bus.i_tx_data = '0;
        wait_clk(4);
        check("rst_rx_data", 32'(bus.o_rx_data), 32'h0);
        check("rst_valid", 32'(bus.o_data_valid), 32'h0);
        check("rst_err", 32'(bus.o_frame_err), 32'h0);
        check("rst_busy", 32'(bus.o_busy), 32'h0);
        check("rst_miso", 32'(bus.miso), 32'h0);
        reset = 1'b1;
        wait_clk(10);

        // Basic frame with reply word
        v0 = valid_cnt; e0 = err_cnt;
        spi_xfer(16'h1234, 16'hA5C3, 16, 10, mw);
        check("f1234_rx", 32'(bus.o_rx_data), 32'h1234);
        check("f1234_valid", 32'(valid_cnt - v0), 32'd1);
        check("f1234_err", 32'(err_cnt - e0), 32'd0);
        check("f1234_miso", 32'(mw), 32'hA5C3);
        check("f1234_busy", 32'(bus.o_busy), 32'h0);

        // Upper bits dropped
        v0 = valid_cnt;
        spi_xfer(16'hFFFF, 16'h0000, 16, 10, mw);
        check("fFFFF_rx", 32'(bus.o_rx_data), 32'h3FFF);
        spi_xfer(16'hC000, 16'hFFFF, 16, 10, mw);
        check("fC000_rx", 32'(bus.o_rx_data), 32'h0000);
        check("fC000_miso", 32'(mw), 32'hFFFF);
        check("fFFFF_C000_valid", 32'(valid_cnt - v0), 32'd2);

        // Aborted frame keeps prior data
        spi_xfer(16'h1555, 16'h0000, 16, 10, mw);
        check("f1555_rx", 32'(bus.o_rx_data), 32'h1555);
        v0 = valid_cnt; e0 = err_cnt;
        spi_xfer(16'hBEEF, 16'h0000, 9, 10, mw);
        check("abort_err", 32'(err_cnt - e0), 32'd1);
        check("abort_valid", 32'(valid_cnt - v0), 32'd0);
        check("abort_rx_kept", 32'(bus.o_rx_data), 32'h1555);
        check("abort_busy", 32'(bus.o_busy), 32'h0);

        // Empty frame: ss toggles without sclk
        v0 = valid_cnt; e0 = err_cnt;
        spi_xfer(16'h0000, 16'h0000, 0, 10, mw);
        check("empty_valid", 32'(valid_cnt - v0), 32'd0);
        check("empty_err", 32'(err_cnt - e0), 32'd0);

        // Overrun: 18 pulses in one window
        v0 = valid_cnt; e0 = err_cnt;
        spi_xfer(16'h0ABC, 16'h8001, 18, 10, mw);
        check("over_rx", 32'(bus.o_rx_data), 32'h0ABC);
        check("over_valid", 32'(valid_cnt - v0), 32'd1);
        check("over_err", 32'(err_cnt - e0), 32'd0);
        check("over_busy", 32'(bus.o_busy), 32'h0);
        check("over_miso", 32'(mw), 32'h8001);

        // ss rises together with the 16th sclk rise
        v0 = valid_cnt; e0 = err_cnt;
        bus.i_tx_data = 16'h0000;
        bus.ss = 1'b0;
        wait_clk(HALF);
        for (int i = 0; i < 15; i++) begin
            mw = 16'h3333;
            sclk_bit(mw[15-i], mb);
        end
        bus.mosi = 1'b1;
        wait_clk(HALF);
        bus.sclk = 1'b1;
        bus.ss = 1'b1;
        wait_clk(10);
        check("same_clk_rx", 32'(bus.o_rx_data), 32'h3333);
        check("same_clk_valid", 32'(valid_cnt - v0), 32'd1);
        check("same_clk_err", 32'(err_cnt - e0), 32'd0);
        check("same_clk_busy", 32'(bus.o_busy), 32'h0);
        wait_clk(HALF);
        bus.sclk = 1'b0;
        wait_clk(HALF);

        // Reset mid-frame, released with ss low
        v0 = valid_cnt; e0 = err_cnt;
        bus.ss = 1'b0;
        wait_clk(HALF);
        for (int i = 0; i < 8; i++) sclk_bit(1'b1, mb);
        reset = 1'b0;
        #1;
        check("midrst_rx", 32'(bus.o_rx_data), 32'h0);
        check("midrst_busy", 32'(bus.o_busy), 32'h0);
        wait_clk(5);
        reset = 1'b1;
        for (int i = 0; i < 8; i++) sclk_bit(1'b1, mb);
        check("midrst_busy_after", 32'(bus.o_busy), 32'h0);
        wait_clk(HALF);
        bus.ss = 1'b1;
        wait_clk(10);
        check("midrst_valid", 32'(valid_cnt - v0), 32'd0);
        check("midrst_err", 32'(err_cnt - e0), 32'd0);
        spi_xfer(16'h0042, 16'h0000, 16, 10, mw);
        check("f0042_rx", 32'(bus.o_rx_data), 32'h0042);

        // Back-to-back frames with 10 clk ss-high gap
        v0 = valid_cnt;
        spi_xfer(16'h0001, 16'hFFFF, 16, 10, mw);
        check("b2b1_rx", 32'(bus.o_rx_data), 32'h0001);
        check("b2b1_miso_idle", 32'(bus.miso), 32'h0);
        spi_xfer(16'h0002, 16'hFFFF, 16, 10, mw);
        check("b2b2_rx", 32'(bus.o_rx_data), 32'h0002);
        check("b2b2_miso_idle", 32'(bus.miso), 32'h0);
        check("b2b_valid", 32'(valid_cnt - v0), 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/spi_slave_if.md
Name: spi_slave_if

Overview:
SPI mode-0 responder core that recovers 16-bit frames from the counter master over sclk/mosi/ss, inside the system clock domain. In the same frame it returns a 16-bit reply word on miso. It delivers the low DATA_BITS of each completed frame plus a one-cycle valid strobe to the display/readback logic. Aborted frames are flagged and never update the output register.

Parameters:
FRAME_BITS, 16, bits per ss-low frame, MSB first
DATA_BITS, 14, width of o_rx_data; taken from the low bits of the received frame
SYNC_STAGES, 2, flip-flop stages on sclk/mosi/ss before edge detection (minimum 2)

Ports:
clk  in  1  system clock, 100 MHz
reset  in  1  asynchronous, active-low reset
sclk  in  1  SPI clock from master, CPOL=0, asynchronous to clk
mosi  in  1  master-out data, sampled on sclk rising edge
ss  in  1  slave select, active-low, frames a transfer
miso  out  1  slave-out data, changes on sclk falling edge
i_tx_data  in  16  reply word, captured at frame start
o_rx_data  out  DATA_BITS  last complete frame, low DATA_BITS bits
o_data_valid  out  1  one-clk pulse when o_rx_data updates
o_frame_err  out  1  one-clk pulse when ss rises with 0 < bits < FRAME_BITS
o_busy  out  1  high while a frame is in progress (state ACTIVE or DONE)

Behaviour:
- Reset (reset=0, async): state=IDLE, bit_cnt=0, rx_shift=0, tx_shift=0, o_rx_data=0, o_data_valid=0, o_frame_err=0, o_busy=0, miso=0; sync flops preset to sclk=0, ss=1.
- sclk, mosi, and ss each pass through SYNC_STAGES flops. Edges are detected against one further registered copy.
- Latency: an internal action follows its pad edge by SYNC_STAGES+1 clk, which is 3 clk at default.
- The master must hold each sclk level for at least SYNC_STAGES+2 clk.
- States:
  - IDLE: miso=0.
    - ss fall: load tx_shift from i_tx_data, drive miso from tx_shift[15], set bit_cnt=0, clear rx_shift, go to ACTIVE.
  - ACTIVE:
    - sclk rise: rx_shift shifts left taking mosi; bit_cnt+1.
    - sclk fall: if bit_cnt is 1 to 15, tx_shift shifts left and miso=tx_shift[15] of the new value.
    - No miso shift on a fall that precedes the first rise.
    - On the rise that makes bit_cnt=FRAME_BITS: o_rx_data <= {rx_shift, mosi}[DATA_BITS-1:0], and o_data_valid pulses on the next clk. Go to DONE.
    - ss rise with bit_cnt < FRAME_BITS: if bit_cnt > 0, o_frame_err pulses for 1 clk. o_rx_data is unchanged. Go to IDLE.
  - DONE:
    - Further sclk edges are ignored; no overrun error is raised.
    - miso holds the last bit.
    - ss rise: go to IDLE.
- ss rising in the same clk as the 16th sclk rise: the frame counts as complete (valid, no error). The ss-rise check uses the post-update bit_cnt.
- The upper FRAME_BITS-DATA_BITS received bits are discarded; no saturation is applied.
- o_rx_data holds its value between frames.
- Reset asserted mid-frame: all state clears immediately.
  - After release with ss already low, no frame starts; the next ss fall is required.
- bit_cnt width is clog2(FRAME_BITS+1) and never wraps; counting stops at FRAME_BITS.
- ss toggling with no sclk edges is an empty frame: no valid, no error.

Test Plan:
- mosi frame 16'h1234, sclk 1 MHz, i_tx_data=16'hA5C3 -> o_rx_data=14'h1234, one o_data_valid pulse, miso bit sequence 1010_0101_1100_0011, o_frame_err stays 0.
- Frame 16'hFFFF -> o_rx_data=14'h3FFF. Then frame 16'hC000 -> o_rx_data=14'h0000, o_data_valid pulses for each frame.
- ss rises after 9 sclk rises of 16'hBEEF -> o_frame_err pulses once, no o_data_valid, o_rx_data keeps its prior value, state returns to IDLE (o_busy=0).
- 18 sclk pulses in one ss window with 16'h0ABC first -> o_rx_data=14'h0ABC, exactly one valid pulse, no error, o_busy falls on ss rise.
- reset=0 after 8 bits of a frame, released while ss is low and sclk continues -> no valid and no error for that frame; next full frame 16'h0042 -> o_rx_data=14'h0042.
- Back-to-back frames 16'h0001 and 16'h0002 with ss high for 10 clk -> two valid pulses, o_rx_data=1 then 2; miso=0 whenever ss is high.
